i2s_tx_fifo_master: RTL and testbench

- Single-clock I2S master transmitter.
- Derives BCLK and LRCLK from the system clock with an integer divider.
- Serialises stereo samples popped from an internal sample FIFO; samples are written through a valid/ready handshake.
- Generalises the existing master: parametrised slot width and FIFO depth, runtime I2S/left-justified mode, underflow handling.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_tx_fifo_master_if.sv | 15 +
 rtl/i2s_sample_fifo.sv | 58 +++++
 rtl/i2s_tx_fifo_master.sv | 145 ++++++++++++++
 tb/tb_i2s_tx_fifo_master.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmit slice.
package i2s_pkg;

  // Serial framing mode (runtime selectable)
  localparam logic MODE_LJ  = 1'b0;
  localparam logic MODE_I2S = 1'b1;

  // Channel select, matches the LRCLK level on the wire
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Pointer width for a FIFO of the given depth (at least one bit)
  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/i2s_tx_fifo_master_if.sv
// Sample-pair write port of the I2S transmitter.
// Handshake: a pair {in_left, in_right} transfers on a rising clk edge where
// in_valid and in_ready are both 1; the source holds data stable while
// in_valid=1 and in_ready=0, and in_ready never depends on in_valid.
interface i2s_tx_fifo_master_if #(
  parameter int DATASIZE = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [DATASIZE-1:0] in_left;
  logic [DATASIZE-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample-pair FIFO with level output and no fall-through:
// rdata is always the oldest stored entry, a push is only visible after its edge.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int PW = fifo_ptr_w(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_fifo_master.sv
// I2S / left-justified master transmitter fed from a sample-pair FIFO.
// Optional macro I2S_TX_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module i2s_tx_fifo_master
  import i2s_pkg::*;
#(
  parameter int DATASIZE  = 16,
  parameter int SLOTSIZE  = 16,
  parameter int CLKDIV    = 4,
  parameter int FIFODEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             i2s_mode,
  i2s_tx_fifo_master_if.slave              in_if,
  output logic [$clog2(FIFODEPTH+1)-1:0]   fifo_level,
  output logic                             underflow,
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  output logic [15:0]                      underflow_count,
`endif
  output logic                             BCLK,
  output logic                             LRCLK,
  output logic                             SDATA
);
  localparam int FRAME = 2 * SLOTSIZE;
  localparam int PW    = $clog2(FRAME);
  localparam int DW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int PAIRW = 2 * DATASIZE;

  localparam logic [PW-1:0] P_LAST   = PW'(FRAME - 1);
  localparam logic [PW-1:0] P_SLOT   = PW'(SLOTSIZE);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [PW-1:0] P_DATA   = PW'(DATASIZE);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0]       div_cnt;
  logic [PW-1:0]       pos;
  logic [PAIRW-1:0]    cur_pair;
  logic                mode_r;
  logic                fall;
  logic                load;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [PAIRW-1:0]    fifo_rdata;
  logic [PW-1:0]       pos_nxt;
  logic [PW-1:0]       load_pos;
  logic [PW-1:0]       q;
  logic                chan;
  logic [PW-1:0]       bidx;
  logic [PAIRW-1:0]    pair_nxt;
  logic [DATASIZE-1:0] smp;
  logic [DATASIZE-1:0] smp_sh;
  logic                bit_nxt;

  assign in_if.in_ready = ~fifo_full;
  assign push           = in_if.in_valid & ~fifo_full;
  assign fall           = enable && (div_cnt == DIV_LAST) && BCLK;
  assign pop            = load & ~fifo_empty;

  i2s_sample_fifo #(
    .WIDTH (PAIRW),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_if.in_left, in_if.in_right}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next frame position, wire-bit selection and the pair that bit comes from
  always_comb begin
    pos_nxt  = (pos == P_LAST) ? '0 : pos + P_ONE;
    q        = pos_nxt;
    load_pos = '0;
    if (mode_r == MODE_I2S) begin
      q        = (pos_nxt == '0) ? P_LAST : pos_nxt - P_ONE;
      load_pos = P_ONE;
    end
    chan     = (q >= P_SLOT) ? RIGHT : LEFT;
    bidx     = (chan == RIGHT) ? q - P_SLOT : q;
    load     = fall && (pos_nxt == load_pos);
    pair_nxt = cur_pair;
    if (load) pair_nxt = fifo_empty ? '0 : fifo_rdata;
    smp      = (chan == LEFT) ? pair_nxt[PAIRW-1:DATASIZE] : pair_nxt[DATASIZE-1:0];
    smp_sh   = smp << bidx;
    bit_nxt  = (bidx < P_DATA) ? smp_sh[DATASIZE-1] : 1'b0;
  end

  // Clock divider, frame sequencer and serial outputs; stop forces idle state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      pos       <= P_LAST;
      cur_pair  <= '0;
      mode_r    <= MODE_LJ;
      BCLK      <= 1'b0;
      LRCLK     <= 1'b0;
      SDATA     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (!enable) begin
        div_cnt  <= '0;
        pos      <= P_LAST;
        cur_pair <= '0;
        mode_r   <= i2s_mode;
        BCLK     <= 1'b0;
        LRCLK    <= 1'b0;
        SDATA    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        BCLK    <= ~BCLK;
        if (BCLK) begin
          pos      <= pos_nxt;
          LRCLK    <= (pos_nxt >= P_SLOT);
          SDATA    <= bit_nxt;
          cur_pair <= pair_nxt;
          if (load && fifo_empty) underflow <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  // Saturating count of frames that started with no data available
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow_count <= '0;
    end else if (underflow && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx_fifo_master.sv
// Directed bench for i2s_tx_fifo_master: DUT a (slot 8) and DUT b (slot 12).
module tb_i2s_tx_fifo_master;

  logic clk;
  logic rst;
  logic en_a, en_b;
  logic mode_a;
  logic [2:0] lvl_a, lvl_b;
  logic uf_a, uf_b;
  logic bclk_a, lrclk_a, sdata_a;
  logic bclk_b, lrclk_b, sdata_b;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  int checks = 0;
  int errors = 0;
  int uf_seen = 0;
  bit sd_any = 0;

  i2s_tx_fifo_master_if #(.DATASIZE(8)) a_if ();
  i2s_tx_fifo_master_if #(.DATASIZE(8)) b_if ();

  i2s_tx_fifo_master #(.DATASIZE(8), .SLOTSIZE(8), .CLKDIV(2), .FIFODEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .i2s_mode(mode_a), .in_if(a_if),
    .fifo_level(lvl_a), .underflow(uf_a),
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    .underflow_count(ucnt_a),
`endif
    .BCLK(bclk_a), .LRCLK(lrclk_a), .SDATA(sdata_a)
  );

  i2s_tx_fifo_master #(.DATASIZE(8), .SLOTSIZE(12), .CLKDIV(2), .FIFODEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .i2s_mode(1'b0), .in_if(b_if),
    .fifo_level(lvl_b), .underflow(uf_b),
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    .underflow_count(ucnt_b),
`endif
    .BCLK(bclk_b), .LRCLK(lrclk_b), .SDATA(sdata_b)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (uf_a === 1'b1) uf_seen++;
    if (sdata_a === 1'b1) sd_any = 1'b1;
  endtask

  task automatic push_a(input logic [7:0] l, input logic [7:0] r);
    a_if.in_valid = 1'b1;
    a_if.in_left  = l;
    a_if.in_right = r;
    tick();
    a_if.in_valid = 1'b0;
  endtask

  // Advance to the next BCLK falling edge of DUT a (sel=0) or b (sel=1)
  task automatic wait_fall(input bit sel, output int n);
    logic prev, now;
    bit done;
    prev = sel ? bclk_b : bclk_a;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      tick();
      n++;
      now = sel ? bclk_b : bclk_a;
      if (prev && !now) done = 1'b1;
      prev = now;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL fall_timeout observed=%0d expected=<200", n);
    end
  endtask

  // Collect nb wire bits, MSB first, one per fall strobe
  task automatic capture(input bit sel, input int nb, output logic [63:0] sd,
                         output logic [63:0] lr, output int first_n, output int tot);
    int n;
    sd = '0;
    lr = '0;
    first_n = 0;
    tot = 0;
    for (int i = 0; i < nb; i++) begin
      wait_fall(sel, n);
      if (i == 0) first_n = n;
      tot += n;
      sd = {sd[62:0], (sel ? sdata_b : sdata_a)};
      lr = {lr[62:0], (sel ? lrclk_b : lrclk_a)};
    end
  endtask

  logic [63:0] sd, lr;
  int first_n, tot, n;

  initial begin
    rst = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    mode_a = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.in_left  = '0;
    a_if.in_right = '0;
    b_if.in_valid = 1'b0;
    b_if.in_left  = '0;
    b_if.in_right = '0;
    #12;
    // Reset state
    check("rst_bclk", 64'(bclk_a), 64'd0);
    check("rst_lrclk", 64'(lrclk_a), 64'd0);
    check("rst_sdata", 64'(sdata_a), 64'd0);
    check("rst_underflow", 64'(uf_a), 64'd0);
    check("rst_level", 64'(lvl_a), 64'd0);
    check("rst_ready", 64'(a_if.in_ready), 64'd1);
    rst = 1'b1;
    tick();

    // Slot 12, data 8: each slot is 8 ones then 4 zeros, frame = 96 clk
    b_if.in_valid = 1'b1;
    b_if.in_left  = 8'hFF;
    b_if.in_right = 8'hFF;
    tick();
    b_if.in_valid = 1'b0;
    en_b = 1'b1;
    capture(1'b1, 24, sd, lr, first_n, tot);
    check("s12_sdata", sd, 64'hFF0FF0);
    check("s12_lrclk", lr, 64'h000FFF);
    wait_fall(1'b1, n);
    check("s12_frame_clk", 64'(tot - first_n + n), 64'd96);
    en_b = 1'b0;
    tick();

    // Left-justified frame
    push_a(8'hA5, 8'h3C);
    check("lj_level", 64'(lvl_a), 64'd1);
    uf_seen = 0;
    en_a = 1'b1;
    capture(1'b0, 16, sd, lr, first_n, tot);
    check("lj_first_strobe", 64'(first_n), 64'd4);
    check("lj_frame_clk", 64'(tot), 64'd64);
    check("lj_sdata", sd, 64'hA53C);
    check("lj_lrclk", lr, 64'h00FF);
    check("lj_no_underflow", 64'(uf_seen), 64'd0);
    wait_fall(1'b0, n);
    check("lj_uf_pulse", 64'(uf_a), 64'd1);
    tick();
    check("lj_uf_one_clk", 64'(uf_a), 64'd0);
    en_a = 1'b0;
    tick();

    // I2S frame: data lags LRCLK by one BCLK
    mode_a = 1'b1;
    tick();
    push_a(8'hA5, 8'h3C);
    uf_seen = 0;
    en_a = 1'b1;
    capture(1'b0, 17, sd, lr, first_n, tot);
    check("i2s_sdata", sd, 64'h0A53C);
    check("i2s_lrclk", lr, 64'h001FE);
    check("i2s_no_underflow", 64'(uf_seen), 64'd0);
    wait_fall(1'b0, n);
    check("i2s_uf_pulse", 64'(uf_a), 64'd1);
    en_a = 1'b0;
    mode_a = 1'b0;
    tick();

    // Empty FIFO: one underflow per frame, silent data
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    uf_seen = 0;
    sd_any = 1'b0;
    en_a = 1'b1;
    capture(1'b0, 48, sd, lr, first_n, tot);
    tick();
    check("empty_uf_count", 64'(uf_seen), 64'd3);
    check("empty_sdata", 64'(sd_any), 64'd0);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    check("empty_uf_counter", 64'(ucnt_a), 64'd3);
`endif
    en_a = 1'b0;
    tick();

    // Fill to depth while stopped; fifth pair is refused
    a_if.in_valid = 1'b1;
    a_if.in_left = 8'hA5; a_if.in_right = 8'h3C; tick();
    a_if.in_left = 8'h96; a_if.in_right = 8'h69; tick();
    a_if.in_left = 8'h80; a_if.in_right = 8'h01; tick();
    a_if.in_left = 8'h33; a_if.in_right = 8'h44; tick();
    check("full_ready", 64'(a_if.in_ready), 64'd0);
    check("full_level", 64'(lvl_a), 64'd4);
    a_if.in_left = 8'h55; a_if.in_right = 8'h66; tick();
    a_if.in_valid = 1'b0;
    check("full_level_hold", 64'(lvl_a), 64'd4);

    // Stop mid-frame at p=5 while BCLK high and SDATA high
    en_a = 1'b1;
    for (int i = 0; i < 6; i++) wait_fall(1'b0, n);
    tick();
    tick();
    check("mid_bclk_high", 64'(bclk_a), 64'd1);
    check("mid_sdata_bit", 64'(sdata_a), 64'd1);
    check("mid_level", 64'(lvl_a), 64'd3);
    en_a = 1'b0;
    tick();
    check("stop_bclk", 64'(bclk_a), 64'd0);
    check("stop_lrclk", 64'(lrclk_a), 64'd0);
    check("stop_sdata", 64'(sdata_a), 64'd0);
    check("stop_level", 64'(lvl_a), 64'd3);

    // Restart picks up the next pair from p=0
    en_a = 1'b1;
    capture(1'b0, 16, sd, lr, first_n, tot);
    check("restart_first_strobe", 64'(first_n), 64'd4);
    check("restart_sdata", sd, 64'h9669);
    check("restart_lrclk", lr, 64'h00FF);
    check("restart_level", 64'(lvl_a), 64'd2);
    wait_fall(1'b0, n);
    tick();
    tick();
    check("pre_rst_sdata", 64'(sdata_a), 64'd1);
    check("pre_rst_level", 64'(lvl_a), 64'd1);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    check("arst_bclk", 64'(bclk_a), 64'd0);
    check("arst_lrclk", 64'(lrclk_a), 64'd0);
    check("arst_sdata", 64'(sdata_a), 64'd0);
    check("arst_level", 64'(lvl_a), 64'd0);
    check("arst_ready", 64'(a_if.in_ready), 64'd1);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    check("arst_uf_counter", 64'(ucnt_a), 64'd0);
`endif
    en_a = 1'b0;
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
